// File: rtl/instr_dispatch_ctrl_if.sv
// Instruction dispatch controller bus.
// Groups the instruction-FIFO handshake, unit start/done strobes, operand
// outputs, data RAM address exchange and controller status signals.
//   master : controller side (instr_dispatch_ctrl)
//   slave  : FIFO / execution-unit / output-mux side
// AW must equal ceil(log2(buffer_size)) of the controller instance.
interface instr_dispatch_ctrl_if #(
  parameter int AW = 10
);
  logic          ififo_empty;
  logic [31:0]   ififo_dout;
  logic          ififo_rd_en;
  logic          start_stp;
  logic          start_evp;
  logic          start_rst;
  logic          done_stp;
  logic          done_evp;
  logic          done_rst;
  logic          rst_instr;
  logic [2:0]    A_out;
  logic [4:0]    N_out;
  logic [AW-1:0] rd_addr_upd_stp;
  logic [AW-1:0] rd_addr_upd_evp;
  logic [AW-1:0] rd_addr_data;
  logic [1:0]    out_sel;
  logic [31:0]   ctl_status;
  logic          ctl_wr_en_s;
  logic          busy;

  modport master (
    input  ififo_empty, ififo_dout, done_stp, done_evp, done_rst,
           rd_addr_upd_stp, rd_addr_upd_evp,
    output ififo_rd_en, start_stp, start_evp, start_rst, rst_instr,
           A_out, N_out, rd_addr_data, out_sel, ctl_status, ctl_wr_en_s, busy
  );

  modport slave (
    output ififo_empty, ififo_dout, done_stp, done_evp, done_rst,
           rd_addr_upd_stp, rd_addr_upd_evp,
    input  ififo_rd_en, start_stp, start_evp, start_rst, rst_instr,
           A_out, N_out, rd_addr_data, out_sel, ctl_status, ctl_wr_en_s, busy
  );
endinterface

// File: rtl/instr_dispatch_ctrl.sv
// Instruction dispatch controller.
// Pops one instruction at a time from the instruction FIFO, decodes it,
// starts the matching execution unit (STP, EVP or RST), waits for that
// unit's completion under a watchdog and takes over the data RAM read
// address the unit hands back. Illegal opcodes and watchdog expiry produce
// a one-cycle ERROR with a status write and a unit reset strobe.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - instr_dispatch_ctrl_if.master (FIFO, unit strobes, operands,
//          read address, out_sel, status, busy)
module instr_dispatch_ctrl #(
  parameter int buffer_size    = 1024,
  parameter int timeout_cycles = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_dispatch_ctrl_if.master bus
);

  localparam int AW  = (buffer_size > 1) ? $clog2(buffer_size) : 1;
  localparam int WDW = 10;
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(timeout_cycles);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam logic [2:0] OP_STP = 3'd0;
  localparam logic [2:0] OP_EVP = 3'd1;
  localparam logic [2:0] OP_RST = 3'd3;

  logic [2:0]     state;
  logic [2:0]     state_nxt;
  logic [2:0]     op_q;
  logic [2:0]     a_q;
  logic [4:0]     n_q;
  logic [WDW-1:0] wd_cnt;
  logic [AW-1:0]  rd_addr_q;
  logic [31:0]    status_q;
  logic           dec_legal;
  logic           done_active;
  logic           wd_expired;
  logic [1:0]     out_sel_c;

  assign dec_legal = (bus.ififo_dout[2:0] == OP_STP) ||
                     (bus.ififo_dout[2:0] == OP_EVP) ||
                     (bus.ififo_dout[2:0] == OP_RST);

  // Only the unit that was started may complete the instruction.
  always_comb begin
    done_active = 1'b0;
    case (op_q)
      OP_STP:  done_active = bus.done_stp;
      OP_EVP:  done_active = bus.done_evp;
      OP_RST:  done_active = bus.done_rst;
      default: done_active = 1'b0;
    endcase
  end

  assign wd_expired = (wd_cnt == WD_LIMIT);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!bus.ififo_empty) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = bus.ififo_empty ? S_IDLE : S_DECODE;
      S_DECODE: state_nxt = dec_legal ? S_START : S_ERROR;
      S_START:  state_nxt = S_WAIT;
      // Completion is checked before the watchdog so a done on the limit
      // cycle still completes normally.
      S_WAIT: begin
        if (done_active)     state_nxt = S_IDLE;
        else if (wd_expired) state_nxt = S_ERROR;
      end
      S_ERROR:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      n_q       <= '0;
      wd_cnt    <= '0;
      rd_addr_q <= '0;
      status_q  <= '1;
    end else begin
      state <= state_nxt;
      case (state)
        S_DECODE: begin
          op_q <= bus.ififo_dout[2:0];
          a_q  <= bus.ififo_dout[5:3];
          n_q  <= bus.ififo_dout[10:6];
          if (!dec_legal) status_q <= 32'h3;
        end
        S_START: wd_cnt <= '0;
        S_WAIT: begin
          if (done_active) begin
            case (op_q)
              OP_STP:  rd_addr_q <= bus.rd_addr_upd_stp;
              OP_EVP:  rd_addr_q <= bus.rd_addr_upd_evp;
              default: rd_addr_q <= '0;
            endcase
          end else if (wd_expired) begin
            status_q <= 32'h4;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_sel_c = 2'd0;
    if (state == S_ERROR) begin
      out_sel_c = 2'd3;
    end else if ((state == S_START) || (state == S_WAIT)) begin
      case (op_q)
        OP_STP:  out_sel_c = 2'd1;
        OP_EVP:  out_sel_c = 2'd2;
        default: out_sel_c = 2'd0;
      endcase
    end
  end

  // Pop gated by empty so a FIFO that drains underneath FETCH is never popped.
  assign bus.ififo_rd_en  = (state == S_FETCH) && !bus.ififo_empty;
  assign bus.start_stp    = (state == S_START) && (op_q == OP_STP);
  assign bus.start_evp    = (state == S_START) && (op_q == OP_EVP);
  assign bus.start_rst    = (state == S_START) && (op_q == OP_RST);
  assign bus.rst_instr    = !((state == S_ERROR) ||
                              ((state == S_START) && (op_q == OP_RST)));
  assign bus.ctl_wr_en_s  = (state == S_ERROR);
  assign bus.busy         = (state != S_IDLE);
  assign bus.out_sel      = out_sel_c;
  assign bus.A_out        = a_q;
  assign bus.N_out        = n_q;
  assign bus.rd_addr_data = rd_addr_q;
  assign bus.ctl_status   = status_q;

endmodule

// File: tb/tb_instr_dispatch_ctrl.sv
// Testbench for instr_dispatch_ctrl: a fixed vector table, hand-written
// multi-cycle sequences (back-to-back issue, watchdog limit/tie, reset in
// WAIT) and randomized instructions checked against an instruction-level
// reference model. The bench models a standard (registered-output)
// instruction FIFO and the execution units' done/address responses.
module tb_instr_dispatch_ctrl;
  localparam int AW = 10;
  localparam int T  = 1023;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_dispatch_ctrl_if #(.AW(AW)) bus ();

  instr_dispatch_ctrl #(
    .buffer_size    (1024),
    .timeout_cycles (T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  a;
    logic [4:0]  n;
    int          lat;
    logic [9:0]  addr;
    bit          spur;
    logic [2:0]  e_start;   // {stp, evp, rst} pulse expected
    logic [1:0]  e_sel;
    int          e_busy;
    bit          e_err;
    logic [9:0]  e_rd;
    logic [31:0] e_status;
  } vec_t;

  vec_t        vecs [8];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] fifo_q [$];
  logic [9:0]  m_rd;
  logic [31:0] m_status;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; the FIFO output register loads on a pop edge.
  task automatic cyc();
    logic pop;
    pop = bus.ififo_rd_en;
    @(posedge clk);
    #1;
    if (pop && fifo_q.size() > 0) bus.ififo_dout = fifo_q.pop_front();
    bus.ififo_empty = (fifo_q.size() == 0);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    bus.ififo_empty = 1'b0;
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rd_en"}, 32'(bus.ififo_rd_en), 0);
    chk({tag, "_starts"}, 32'({bus.start_stp, bus.start_evp, bus.start_rst}), 0);
    chk({tag, "_wr_en"}, 32'(bus.ctl_wr_en_s), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_out_sel"}, 32'(bus.out_sel), 0);
    chk({tag, "_A_out"}, 32'(bus.A_out), 0);
    chk({tag, "_N_out"}, 32'(bus.N_out), 0);
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr_data), 0);
    chk({tag, "_rst_instr"}, 32'(bus.rst_instr), 1);
    chk({tag, "_status"}, bus.ctl_status, 32'hFFFF_FFFF);
  endtask

  // Runs one instruction from issue to return to IDLE while acting as the
  // started unit: done after lat cycles (0 = never), optionally preceded by
  // a done pulse from a different unit.
  task automatic run_instr(input logic [31:0] word, input int lat, input logic [9:0] addr,
                           input bit spur, input bit do_push, input logic [2:0] e_start,
                           input logic [1:0] e_sel, input int e_busy, input bit e_err,
                           input logic [9:0] e_rd, input logic [31:0] e_status);
    logic [2:0] op;
    int g, idx, bcnt, st_idx, npop, nstp, nevp, nrst, nwr;
    int err_bad, rlow, pair_bad, sel_bad, empty_pop;
    op = word[2:0];
    bus.rd_addr_upd_stp = (op == 3'd1) ? ~addr : addr;
    bus.rd_addr_upd_evp = (op == 3'd0) ? ~addr : addr;
    if (do_push) push(word);
    g = 0;
    while (!bus.busy && g < 8) begin
      cyc();
      g++;
    end
    chk("issue", 32'(bus.busy), 1);
    idx = 0; bcnt = 0; st_idx = -1; npop = 0; nstp = 0; nevp = 0; nrst = 0;
    nwr = 0; err_bad = 0; rlow = 0; pair_bad = 0; sel_bad = 0; empty_pop = 0;
    while (bus.busy && idx < 3000) begin
      bcnt++;
      if (bus.ififo_rd_en) npop++;
      if (bus.ififo_rd_en && bus.ififo_empty) empty_pop++;
      if (bus.start_stp) nstp++;
      if (bus.start_evp) nevp++;
      if (bus.start_rst) nrst++;
      if (bus.start_stp || bus.start_evp || bus.start_rst) st_idx = idx;
      if (bus.start_rst && bus.rst_instr) pair_bad++;
      if (bus.ctl_wr_en_s) begin
        nwr++;
        if (bus.out_sel !== 2'd3 || bus.rst_instr !== 1'b0) err_bad++;
      end
      if (!bus.rst_instr) rlow++;
      if (st_idx >= 0 && idx > st_idx && !bus.ctl_wr_en_s && bus.out_sel !== e_sel) sel_bad++;
      bus.done_stp = 1'b0;
      bus.done_evp = 1'b0;
      bus.done_rst = 1'b0;
      if (st_idx >= 0 && lat > 0 && idx == st_idx + lat) begin
        if (op == 3'd0) bus.done_stp = 1'b1;
        if (op == 3'd1) bus.done_evp = 1'b1;
        if (op == 3'd3) bus.done_rst = 1'b1;
      end
      if (spur && st_idx >= 0 && lat >= 2 && idx == st_idx + lat - 1) begin
        if (op == 3'd0) bus.done_evp = 1'b1;
        else            bus.done_stp = 1'b1;
      end
      cyc();
      idx++;
    end
    bus.done_stp = 1'b0;
    bus.done_evp = 1'b0;
    bus.done_rst = 1'b0;
    chk("pop_count", npop, 1);
    chk("pop_while_empty", empty_pop, 0);
    chk("start_pulses", nstp * 100 + nevp * 10 + nrst,
        int'(e_start[2]) * 100 + int'(e_start[1]) * 10 + int'(e_start[0]));
    chk("busy_cycles", bcnt, e_busy);
    chk("out_sel_wait", sel_bad, 0);
    chk("err_strobe", nwr, int'(e_err));
    chk("err_outputs", err_bad, 0);
    chk("rst_instr_low", rlow, int'(e_err) + int'(e_start[0]));
    chk("rst_with_start", pair_bad, 0);
    chk("A_out", 32'(bus.A_out), 32'(word[5:3]));
    chk("N_out", 32'(bus.N_out), 32'(word[10:6]));
    chk("rd_addr", 32'(bus.rd_addr_data), 32'(e_rd));
    chk("status", bus.ctl_status, e_status);
    m_rd     = e_rd;
    m_status = e_status;
  endtask

  // Instruction-level reference model: outcome from opcode legality and
  // unit response latency versus the watchdog limit.
  task automatic model_run(input logic [31:0] word, input int lat, input logic [9:0] addr,
                           input bit spur, input bit do_push);
    logic [2:0]  op;
    logic [2:0]  e_start;
    logic [1:0]  e_sel;
    logic [9:0]  e_rd;
    logic [31:0] e_status;
    int          e_busy;
    bit          e_err;
    op = word[2:0];
    e_start = 3'b000; e_sel = 2'd0; e_err = 1'b0; e_rd = m_rd; e_status = m_status;
    if (!(op == 3'd0 || op == 3'd1 || op == 3'd3)) begin
      e_err = 1'b1; e_busy = 3; e_status = 32'h3;
    end else begin
      e_start = (op == 3'd0) ? 3'b100 : (op == 3'd1) ? 3'b010 : 3'b001;
      e_sel   = (op == 3'd0) ? 2'd1 : (op == 3'd1) ? 2'd2 : 2'd0;
      if (lat >= 1 && lat <= T + 1) begin
        e_busy = 3 + lat;
        e_rd   = (op == 3'd3) ? 10'd0 : addr;
      end else begin
        e_busy = T + 5; e_err = 1'b1; e_status = 32'h4;
      end
    end
    run_instr(word, lat, addr, spur, do_push, e_start, e_sel, e_busy, e_err, e_rd, e_status);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] w, w2;
    int n, g;
    rst = 1'b0;
    bus.ififo_empty = 1'b1;
    bus.ififo_dout = '0;
    bus.done_stp = 1'b0; bus.done_evp = 1'b0; bus.done_rst = 1'b0;
    bus.rd_addr_upd_stp = '0; bus.rd_addr_upd_evp = '0;
    m_rd = '0; m_status = 32'hFFFF_FFFF;

    vecs[0] = '{3'd0, 3'd2, 5'd3,  6, 10'd5,    1'b0, 3'b100, 2'd1, 9, 1'b0, 10'd5,    32'hFFFF_FFFF};
    vecs[1] = '{3'd2, 3'd1, 5'd1,  0, 10'd0,    1'b0, 3'b000, 2'd0, 3, 1'b1, 10'd5,    32'h3};
    vecs[2] = '{3'd1, 3'd7, 5'd31, 1, 10'd1023, 1'b0, 3'b010, 2'd2, 4, 1'b0, 10'd1023, 32'h3};
    vecs[3] = '{3'd0, 3'd0, 5'd0,  4, 10'd17,   1'b1, 3'b100, 2'd1, 7, 1'b0, 10'd17,   32'h3};
    vecs[4] = '{3'd3, 3'd5, 5'd9,  2, 10'd600,  1'b1, 3'b001, 2'd0, 5, 1'b0, 10'd0,    32'h3};
    vecs[5] = '{3'd7, 3'd3, 5'd4,  0, 10'd0,    1'b0, 3'b000, 2'd0, 3, 1'b1, 10'd0,    32'h3};
    vecs[6] = '{3'd1, 3'd1, 5'd2,  3, 10'd300,  1'b1, 3'b010, 2'd2, 6, 1'b0, 10'd300,  32'h3};
    vecs[7] = '{3'd4, 3'd6, 5'd17, 0, 10'd0,    1'b0, 3'b000, 2'd0, 3, 1'b1, 10'd300,  32'h3};

    for (int i = 0; i < 3; i++) cyc();
    check_reset_vals("reset");
    rst = 1'b1;
    cyc();

    for (int i = 0; i < 8; i++) begin
      w = {21'd0, vecs[i].n, vecs[i].a, vecs[i].op};
      run_instr(w, vecs[i].lat, vecs[i].addr, vecs[i].spur, 1'b1, vecs[i].e_start,
                vecs[i].e_sel, vecs[i].e_busy, vecs[i].e_err, vecs[i].e_rd, vecs[i].e_status);
    end

    // Back-to-back STP then RST already queued: second pop only after first done.
    w  = {21'd0, 5'd11, 3'd4, 3'd0};
    w2 = {21'd0, 5'd6,  3'd1, 3'd3};
    push(w);
    push(w2);
    model_run(w, 3, 10'd44, 1'b0, 1'b0);
    model_run(w2, 1, 10'd77, 1'b0, 1'b0);

    // Watchdog: done exactly on the limit cycle wins; no done at all -> ERROR.
    model_run({21'd0, 5'd2, 3'd3, 3'd0}, T + 1, 10'd512, 1'b0, 1'b1);
    model_run({21'd0, 5'd9, 3'd6, 3'd1}, 0, 10'd123, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      w = $urandom();
      w[2:0] = 3'($urandom_range(0, 7));
      model_run(w, int'($urandom_range(1, 12)), 10'($urandom()), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset asserted mid-WAIT abandons the instruction.
    bus.rd_addr_upd_stp = 10'd9;
    push({21'd0, 5'd3, 3'd2, 3'd0});
    g = 0;
    while (!bus.start_stp && g < 10) begin
      cyc();
      g++;
    end
    chk("rst_seq_start", 32'(bus.start_stp), 1);
    cyc();
    cyc();
    chk("rst_seq_wait_sel", 32'(bus.out_sel), 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("async_rst");
    cyc();
    #1;
    rst = 1'b1;
    n = 0;
    bus.done_stp = 1'b1;
    cyc();
    bus.done_stp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.start_stp || bus.start_evp || bus.start_rst) n++;
      cyc();
    end
    chk("post_rst_starts", n, 0);
    chk("post_rst_rd_addr", 32'(bus.rd_addr_data), 0);
    chk("post_rst_busy", 32'(bus.busy), 0);
    m_rd = '0;
    m_status = 32'hFFFF_FFFF;

    model_run({21'd0, 5'd1, 3'd1, 3'd1}, 2, 10'd88, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_dispatch_ctrl.md
INSTR_DISPATCH_CTRL -- requirements
Module: instr_dispatch_ctrl

Interface
REQ-001 Parameter buffer_size, default 1024: data RAM depth; AW = ceil(log2(buffer_size)).
REQ-002 Parameter timeout_cycles, default 1023: watchdog limit per instruction; counter width 10 bits.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 ififo_empty  input  1  instruction FIFO empty flag.
REQ-006 ififo_dout  input  32  instruction word; [2:0] opcode, [5:3] A, [10:6] N.
REQ-007 ififo_rd_en  output  1  one-cycle pop of instruction FIFO.
REQ-008 start_stp / start_evp / start_rst  output  1 each  one-cycle unit start pulses.
REQ-009 done_stp / done_evp / done_rst  input  1 each  unit completion pulses.
REQ-010 rst_instr  output  1  active-low per-unit reset strobe.
REQ-011 A_out  output  3;  N_out  output  5  latched operands to units.
REQ-012 rd_addr_upd_stp / rd_addr_upd_evp  input  AW each  unit-updated data RAM read address.
REQ-013 rd_addr_data  output  AW  data RAM read address owned by controller.
REQ-014 out_sel  output  2  output FIFO mux select: 0 none, 1 STP, 2 EVP, 3 controller.
REQ-015 ctl_status  output  32;  ctl_wr_en_s  output  1  controller status word and write strobe.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, FETCH, DECODE, START, WAIT, ERROR.
REQ-018 IDLE -> FETCH when ififo_empty=0; FETCH asserts ififo_rd_en for exactly one cycle.
REQ-019 DECODE latches ififo_dout into instr register; A_out/N_out update from it in DECODE.
REQ-020 Opcodes: 0 STP, 1 EVP, 3 RST; opcodes 2, 4-7 illegal -> ERROR with ctl_status=32'h3.
REQ-021 START asserts exactly one start_* pulse for one cycle, sets out_sel (STP 1, EVP 2, RST 0), then -> WAIT.
REQ-022 WAIT holds out_sel; only the done_* of the active unit is honoured; done from an inactive unit is ignored.
REQ-023 On active done in WAIT: rd_addr_data <= rd_addr_upd_stp (STP) or rd_addr_upd_evp (EVP); RST sets rd_addr_data <= 0; next state IDLE, out_sel <= 0.
REQ-024 Watchdog counts WAIT cycles from 0; on reaching timeout_cycles without done -> ERROR with ctl_status=32'h4.
REQ-025 ERROR lasts one cycle: out_sel=3, ctl_wr_en_s=1, rst_instr=0 (units reset), then IDLE.
REQ-026 RST opcode also drives rst_instr=0 for the START cycle in addition to start_rst.
REQ-027 Done arriving in the same cycle watchdog reaches limit: done wins, no error.
REQ-028 Instruction issue is serialized: no FETCH while busy; minimum 4 cycles IDLE-to-IDLE for zero-latency unit.
REQ-029 rd_addr_data wraps modulo buffer_size; controller performs no range check.
REQ-030 ififo_rd_en never asserted while ififo_empty=1.

Reset
REQ-031 rst=0 asynchronously forces IDLE; ififo_rd_en, start_*, ctl_wr_en_s, busy, out_sel, A_out, N_out, rd_addr_data, watchdog = 0; rst_instr=1; ctl_status=32'hFFFFFFFF.
REQ-032 rst asserted mid-WAIT abandons instruction; after release no start_* pulse until a new FETCH.

Verification
REQ-033 Push STP word A=2,N=3, done_stp 6 cycles after start with rd_addr_upd_stp=5 -> one ififo_rd_en, one start_stp, out_sel=1 during WAIT, rd_addr_data=5, IDLE.
REQ-034 Push opcode 2 -> no start_* pulse, ERROR cycle with ctl_status=32'h3, ctl_wr_en_s=1, out_sel=3, rst_instr=0.
REQ-035 EVP start, no done for 1023 cycles -> ERROR with ctl_status=32'h4, rst_instr=0 one cycle, then IDLE.
REQ-036 STP active, spurious done_evp pulse then done_stp -> completion only on done_stp, rd_addr_data from STP input.
REQ-037 Two back-to-back instructions (STP then RST) in FIFO -> second pop only after first done; RST clears rd_addr_data to 0.
REQ-038 Assert rst during WAIT -> all outputs at reset values immediately; no completion update on later done_stp.
